muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed 32-bit multiplier and divider pair with one shared shift/add datapath. It supports signed and unsigned MULT/DIV with a start/ready handshake, annul, and early divide-by-zero completion. EX holds `stallreq_for_ex` while `busy_o` is high and writes `hi_o`/`lo_o` into the HI/LO bus when `ready_o` pulses.

---
 rtl/muldiv_unit_pkg.sv | 21 ++
 rtl/muldiv_sign_fix.sv | 45 ++++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op_i encodings (bit 1 = divide, bit 0 = signed)
//   - FSM state encoding
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage : muldiv_unit_pkg

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational sign correction of the unsigned 2*WIDTH result produced by the
// shared accumulator.
//   op_i       : operation (encodings in muldiv_unit_pkg)
//   neg_res_i  : product / quotient must be negated
//   neg_rem_i  : remainder must be negated
//   res_i      : {hi, lo} magnitude result
//   res_o      : {hi, lo} signed-corrected result
// -----------------------------------------------------------------------------
module muldiv_sign_fix
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         op_i,
  input  logic               neg_res_i,
  input  logic               neg_rem_i,
  input  logic [2*WIDTH-1:0] res_i,
  output logic [2*WIDTH-1:0] res_o
);

  logic [WIDTH-1:0] hi, lo;

  assign hi = res_i[2*WIDTH-1:WIDTH];
  assign lo = res_i[WIDTH-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    res_o = res_i;
    case (op_i)
      OP_MULTU, OP_DIVU: ;
      // Product is a single 2*WIDTH number, negated as a whole.
      OP_MULT: if (neg_res_i) res_o = -res_i;
      // Quotient and remainder carry independent signs. MIN / -1 wraps back to
      // MIN in the quotient with a zero remainder, which is the intended result.
      OP_DIV: begin
        res_o[WIDTH-1:0]       = neg_res_i ? -lo : lo;
        res_o[2*WIDTH-1:WIDTH] = neg_rem_i ? -hi : hi;
      end
    endcase
  end

endmodule : muldiv_sign_fix

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative signed/unsigned multiply and divide on one shared 2*WIDTH
// shift/add accumulator. WIDTH steps per operation, then a sign-fix cycle.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : request, sampled in IDLE or DONE
//   op_i          : [1] divide, [0] signed
//   opa_i, opb_i  : multiplicand/dividend, multiplier/divisor
//   annul_i       : abort the operation in flight (wins over start_i)
//   busy_o        : high in RUN or FIX
//   ready_o       : one-cycle completion pulse (DONE)
//   hi_o, lo_o    : product high/low, or remainder/quotient
//   div_zero_o    : last completed divide had a zero divisor
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dz_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] fixed;

  // Signed ops work on magnitudes; the signs are restored in FIX.
  assign a_mag = (op_i[0] && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign b_mag = (op_i[0] && opb_i[WIDTH-1]) ? -opb_i : opb_i;

  // One iteration of the shared datapath. Multiply: acc = {partial, multiplier}
  // shifted right each step. Divide: acc = {remainder, quotient} shifted left,
  // the quotient bit entering at the bottom.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge  = (rem_sh >= {1'b0, b_q});
    // Only used when rem_ge: the difference is then below b_q and fits WIDTH.
    rem_sub = rem_sh[WIDTH-1:0] - b_q;
    if (op_q[1]) begin
      acc_d = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op_i      (op_q),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .res_i     (acc_q),
    .res_o     (fixed)
  );

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (start_i && !annul_i) begin
            op_q      <= op_i;
            b_q       <= b_mag;
            acc_q     <= {{WIDTH{1'b0}}, a_mag};
            cnt_q     <= '0;
            neg_res_q <= op_i[0] & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            neg_rem_q <= op_i[0] & opa_i[WIDTH-1];
            if (op_i[1] && (opb_i == '0)) begin
              // Divide by zero completes immediately without iterating.
              hi_q    <= opa_i;
              lo_q    <= '1;
              dz_q    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            hi_q    <= fixed[2*WIDTH-1:WIDTH];
            lo_q    <= fixed[WIDTH-1:0];
            dz_q    <= 1'b0;
            state_q <= S_DONE;
          end
        end
      endcase
    end
  end

  assign busy_o     = (state_q == S_RUN) || (state_q == S_FIX);
  assign ready_o    = (state_q == S_DONE);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit (WIDTH = 32). The driver pushes the
// expected result of every accepted request; a monitor pops and compares on
// each ready_o pulse. Expected values come from plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic          clk, rst, start_i, annul_i;
  logic [1:0]    op_i;
  logic [W-1:0]  opa_i, opb_i;
  logic          busy_o, ready_o, div_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .annul_i    (annul_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: 64-bit arithmetic; SV signed division truncates toward zero and
  // the remainder follows the dividend, which is exactly the required behaviour.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    logic [63:0] p;
    longint sa, sb, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.dz = 1'b0;
    p = '0;
    if (op[1] && b == '0) begin
      p = {a, {W{1'b1}}};
      r.dz = 1'b1;
    end else if (op == OP_MULTU) begin
      p = {32'b0, a} * {32'b0, b};
    end else if (op == OP_MULT) begin
      p = sa * sb;
    end else if (op == OP_DIVU) begin
      p = {a % b, a / b};
    end else begin
      q = sa / sb;
      m = sa % sb;
      p = {m[31:0], q[31:0]};
    end
    r.hi = p[63:32];
    r.lo = p[31:0];
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every ready_o pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ready_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: ready_o=1 with no request outstanding at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("hi_o", 64'(hi_o), 64'(mon_e.hi));
          check("lo_o", 64'(lo_o), 64'(mon_e.lo));
          check("div_zero_o", 64'(div_zero_o), 64'(mon_e.dz));
          last_exp = mon_e;
        end
      end
    end
  end

  // Issue one request at the current (negedge-aligned) point and wait for its
  // completion. Returns at the negedge of the ready cycle, so a following call
  // starts during DONE (back-to-back).
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    bit   got;
    e = model(op, a, b);
    op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    // Operands are captured at accept; scramble them to prove it.
    start_i = 1'b0; op_i = 2'($urandom); opa_i = $urandom; opb_i = $urandom;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (ready_o) got = 1'b1;
      else check("busy_in_flight", 64'(busy_o), 64'd1);
    end
    check("latency", 64'(n), e.dz ? 64'd1 : 64'(W + 2));
    check("busy_at_ready", 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    op_i = '0; opa_i = '0; opb_i = '0;
    last_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_dz", 64'(div_zero_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue(OP_MULT,  32'hFFFF_FFFE, 32'd3);
    @(negedge clk); issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk); issue(OP_DIVU,  32'd100, 32'd7);
    @(negedge clk); issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    @(negedge clk); issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk); issue(OP_DIV,   32'd5, 32'd0);
    // Back-to-back: second start lands in the DONE cycle of the first.
    @(negedge clk); issue(OP_DIVU,  32'd100, 32'd7);
    issue(OP_MULT, 32'h1234_5678, 32'h8765_4321);
    issue(OP_DIVU, 32'd9, 32'd0);
    issue(OP_DIV,  32'd7, 32'hFFFF_FFFE);

    // Annul in cycle 10 of a DIVU: no ready, outputs keep prior values.
    @(negedge clk);
    op_i = OP_DIVU; opa_i = 32'd1000; opb_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1 annul_i = 1'b0;
    @(negedge clk);
    check("annul_busy", 64'(busy_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_hi_hold", 64'(hi_o), 64'(last_exp.hi));
    check("annul_lo_hold", 64'(lo_o), 64'(last_exp.lo));
    check("annul_dz_hold", 64'(div_zero_o), 64'(last_exp.dz));
    repeat (40) @(negedge clk);

    // Annul together with start: nothing is accepted.
    op_i = OP_MULT; opa_i = 32'd3; opb_i = 32'd4; start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);
    check("annul_start_busy", 64'(busy_o), 64'd0);
    repeat (40) @(negedge clk);

    // Reset in cycle 5 of a multiply: everything returns to zero, no ready.
    op_i = OP_MULTU; opa_i = 32'd77; opb_i = 32'd55; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_hi", 64'(hi_o), 64'd0);
    check("midrst_lo", 64'(lo_o), 64'd0);
    check("midrst_dz", 64'(div_zero_o), 64'd0);
    last_exp = '0;
    repeat (40) @(negedge clk);

    // Randomized traffic, mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(rop, ra, rb);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_muldiv_unit
